// File: rtl/mio_bus_ctrl_pkg.sv
// mio_bus_ctrl_pkg: FSM states, region decode constants, select indices and default RAM latency
package mio_bus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;
  localparam int RAM_LAT_DEF = 2;
  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE = 32'hE000_0000;
  localparam logic [31:0] GPIO_MASK = 32'hF000_0000;
  localparam logic [31:0] CNT_BASE = 32'hF000_0000;
  localparam logic [31:0] CNT_MASK = 32'hF000_0000;
  localparam int SEL_RAM = 0;
  localparam int SEL_GPIO = 1;
  localparam int SEL_CNT = 2;
  localparam int SEL_NONE = 3;
endpackage

// File: rtl/mio_addr_dec.sv
// mio_addr_dec: i_addr byte address -> o_sel one-hot {none, counter, gpio, ram}
module mio_addr_dec
  import mio_bus_ctrl_pkg::*;
(
  input  logic [31:0] i_addr,
  output logic [3:0]  o_sel
);
  assign o_sel[SEL_RAM] = (i_addr & RAM_MASK) == RAM_BASE;
  assign o_sel[SEL_GPIO] = (i_addr & GPIO_MASK) == GPIO_BASE;
  assign o_sel[SEL_CNT] = (i_addr & CNT_MASK) == CNT_BASE;
  assign o_sel[SEL_NONE] = ~|o_sel[SEL_CNT:SEL_RAM];
endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU MemRead/MemWrite bridge to RAM (RAM_LAT wait), GPIO and counter with MIO_ready pulse and sticky addr_err
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout,
  input  logic [31:0] gpio_in,
  output logic        gpio_we,
  input  logic [31:0] cnt_val,
  output logic        cnt_we,
  output logic [31:0] periph_wdata,
  output logic        addr_err
);
  state_t r_state, w_next;
  logic [1:0] r_wait, w_wait;
  logic [3:0] w_sel;
  logic [31:0] r_rdata, r_pwdata;
  logic r_err;
  logic w_launch, w_rd, w_cap;
  mio_addr_dec u_dec (.i_addr(cpu_addr), .o_sel(w_sel));
  assign w_rd = MemRead & ~MemWrite;
  assign w_launch = (r_state == IDLE) & (MemRead | MemWrite);
  assign w_cap = (r_state == RAM_WAIT) & MemRead & (r_wait == 2'd0);
  assign ram_addr = cpu_addr[11:2];
  assign ram_din = cpu_wdata;
  assign ram_we = w_launch & MemWrite & w_sel[SEL_RAM] & ~reset;
  assign gpio_we = w_launch & MemWrite & w_sel[SEL_GPIO] & ~reset;
  assign cnt_we = w_launch & MemWrite & w_sel[SEL_CNT] & ~reset;
  assign MIO_ready = r_state == DONE;
  assign cpu_rdata = r_rdata;
  assign periph_wdata = r_pwdata;
  assign addr_err = r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wait <= 2'd0;
    end else begin
      r_state <= w_next;
      r_wait <= w_wait;
    end
  end
  always_comb begin
    w_next = r_state;
    w_wait = r_wait;
    case (r_state)
      IDLE: if (w_launch) begin
        w_next = (w_rd & w_sel[SEL_RAM]) ? RAM_WAIT : DONE;
        w_wait = 2'(RAM_LAT - 1);
      end
      RAM_WAIT: begin
        w_next = !MemRead ? IDLE : (r_wait == 2'd0) ? DONE : RAM_WAIT;
        w_wait = (r_wait == 2'd0) ? r_wait : r_wait - 2'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_pwdata <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_launch & w_rd & ~w_sel[SEL_RAM])
        r_rdata <= w_sel[SEL_GPIO] ? gpio_in : w_sel[SEL_CNT] ? cnt_val : '0;
      else if (w_cap)
        r_rdata <= ram_dout;
      if (w_launch & MemWrite & (w_sel[SEL_GPIO] | w_sel[SEL_CNT]))
        r_pwdata <= cpu_wdata;
      if (w_launch & w_sel[SEL_NONE])
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: table-driven and hand-sequenced checks of mio_bus_ctrl with RAM_LAT=2
module tb_mio_bus_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ram_dout = '0, gpio_in = '0, cnt_val = '0;
  logic [31:0] cpu_rdata, ram_din, periph_wdata;
  logic [9:0] ram_addr;
  logic MIO_ready, ram_we, gpio_we, cnt_we, addr_err;
  int n_cmp = 0;
  int n_bad = 0;
  logic got;
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] gpio;
    logic [31:0] cnt;
    logic [2:0] we;
    logic [31:0] rdata;
    logic [31:0] pw;
    logic err;
  } vec_t;
  vec_t v[11];
  mio_bus_ctrl #(.RAM_LAT(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .gpio_in(gpio_in), .gpio_we(gpio_we),
    .cnt_val(cnt_val), .cnt_we(cnt_we), .periph_wdata(periph_wdata), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b1, 32'hE000_0000, 32'h0000_00FF, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0000_00FF, 1'b0};
    v[1]  = '{1'b0, 1'b1, 32'hF000_0010, 32'h0000_1234, 32'h0, 32'h0, 3'b001, 32'h0, 32'h0000_1234, 1'b0};
    v[2]  = '{1'b1, 1'b0, 32'hE123_4560, 32'h0, 32'hA5A5_0001, 32'h0, 3'b000, 32'hA5A5_0001, 32'h0000_1234, 1'b0};
    v[3]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_00C8, 3'b000, 32'h0000_00C8, 32'h0000_1234, 1'b0};
    v[4]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0077, 32'h0, 32'h0, 3'b100, 32'h0000_00C8, 32'h0000_1234, 1'b0};
    v[5]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_0005, 32'h0, 32'h0, 3'b100, 32'h0000_00C8, 32'h0000_1234, 1'b0};
    v[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0066, 32'h0, 32'h0, 3'b000, 32'h0000_00C8, 32'h0000_1234, 1'b1};
    v[7]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0000_1234, 1'b1};
    v[8]  = '{1'b1, 1'b0, 32'hEFFF_FFFF, 32'h0, 32'h0000_0011, 32'h0, 3'b000, 32'h0000_0011, 32'h0000_1234, 1'b1};
    v[9]  = '{1'b0, 1'b1, 32'hDFFF_FFFC, 32'h0000_0009, 32'h0, 32'h0, 3'b000, 32'h0000_0011, 32'h0000_1234, 1'b1};
    v[10] = '{1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 32'h0000_0022, 3'b000, 32'h0000_0022, 32'h0000_1234, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ready", {31'b0, MIO_ready}, 32'h0);
    chk("rst_pwdata", periph_wdata, 32'h0);
    chk("rst_err", {31'b0, addr_err}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      MemRead = v[i].rd;
      MemWrite = v[i].wr;
      cpu_addr = v[i].addr;
      cpu_wdata = v[i].wdata;
      gpio_in = v[i].gpio;
      cnt_val = v[i].cnt;
      #1;
      chk($sformatf("v%0d_we", i), {29'b0, ram_we, gpio_we, cnt_we}, {29'b0, v[i].we});
      chk($sformatf("v%0d_rdy0", i), {31'b0, MIO_ready}, 32'h0);
      chk($sformatf("v%0d_din", i), ram_din, v[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), {31'b0, MIO_ready}, 32'h1);
      chk($sformatf("v%0d_we_off", i), {29'b0, ram_we, gpio_we, cnt_we}, 32'h0);
      chk($sformatf("v%0d_rdata", i), cpu_rdata, v[i].rdata);
      chk($sformatf("v%0d_pwdata", i), periph_wdata, v[i].pw);
      chk($sformatf("v%0d_err", i), {31'b0, addr_err}, {31'b0, v[i].err});
      MemRead = 1'b0;
      MemWrite = 1'b0;
    end
    @(negedge clk);
    MemRead = 1'b1;
    cpu_addr = 32'h0000_0010;
    ram_dout = 32'hDEAD_BEEF;
    #1;
    chk("ram_addr", {22'b0, ram_addr}, 32'h4);
    chk("rd_we", {29'b0, ram_we, gpio_we, cnt_we}, 32'h0);
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (MIO_ready) begin
        got = 1'b1;
        chk("rd_lat", 32'(k), 32'd3);
        chk("rd_data", cpu_rdata, 32'h1234_5678);
      end
      ram_dout = (k == 2) ? 32'h1234_5678 : 32'hDEAD_BEEF;
    end
    chk("rd_timeout", {31'b0, got}, 32'h1);
    MemRead = 1'b0;
    @(negedge clk);
    chk("rd_rdy_off", {31'b0, MIO_ready}, 32'h0);
    chk("rd_hold", cpu_rdata, 32'h1234_5678);
    @(negedge clk);
    MemRead = 1'b1;
    cpu_addr = 32'h0000_0020;
    ram_dout = 32'hAAAA_5555;
    @(negedge clk);
    chk("ab_rdy0", {31'b0, MIO_ready}, 32'h0);
    MemRead = 1'b0;
    @(negedge clk);
    chk("ab_rdy1", {31'b0, MIO_ready}, 32'h0);
    chk("ab_rdata", cpu_rdata, 32'h1234_5678);
    MemWrite = 1'b1;
    cpu_addr = 32'h0000_0004;
    cpu_wdata = 32'h3;
    #1;
    chk("ab_idle_we", {31'b0, ram_we}, 32'h1);
    @(negedge clk);
    chk("ab_wr_rdy", {31'b0, MIO_ready}, 32'h1);
    MemWrite = 1'b0;
    @(negedge clk);
    MemWrite = 1'b1;
    cpu_addr = 32'hF000_0000;
    cpu_wdata = 32'h55;
    #1;
    chk("b2b_we1", {29'b0, ram_we, gpio_we, cnt_we}, 32'h1);
    @(negedge clk);
    chk("b2b_rdy1", {31'b0, MIO_ready}, 32'h1);
    chk("b2b_we_off", {31'b0, cnt_we}, 32'h0);
    @(negedge clk);
    chk("b2b_we2", {31'b0, cnt_we}, 32'h1);
    chk("b2b_rdy_off", {31'b0, MIO_ready}, 32'h0);
    @(negedge clk);
    chk("b2b_rdy2", {31'b0, MIO_ready}, 32'h1);
    MemWrite = 1'b0;
    @(negedge clk);
    MemRead = 1'b1;
    cpu_addr = 32'h0000_0008;
    ram_dout = 32'h0F0F_0F0F;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_rdy", {31'b0, MIO_ready}, 32'h0);
    chk("rs_rdata", cpu_rdata, 32'h0);
    chk("rs_err", {31'b0, addr_err}, 32'h0);
    chk("rs_pwdata", periph_wdata, 32'h0);
    MemRead = 1'b0;
    MemWrite = 1'b1;
    cpu_addr = 32'hE000_0000;
    #1;
    chk("rs_we_supp", {29'b0, ram_we, gpio_we, cnt_we}, 32'h0);
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_rdy_after", {31'b0, MIO_ready}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mio_bus_ctrl.md
MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 Parameter RAM_LAT, default 2, RAM read wait cycles between launch and data capture; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 MemRead  input  1  CPU read request; held high by the requester until MIO_ready.
REQ-005 MemWrite  input  1  CPU write request; held high by the requester until MIO_ready.
REQ-006 cpu_addr  input  32  byte address; must be stable while a request is held.
REQ-007 cpu_wdata  input  32  write data; must be stable while a request is held.
REQ-008 cpu_rdata  output  32  registered read data.
REQ-009 MIO_ready  output  1  one-cycle completion pulse to the multicycle controller.
REQ-010 ram_addr  output  10  RAM word index, cpu_addr[11:2].
REQ-011 ram_din  output  32  RAM write data.
REQ-012 ram_we  output  1  RAM write strobe.
REQ-013 ram_dout  input  32  RAM read data, valid RAM_LAT cycles after the address is presented.
REQ-014 gpio_in  input  32  switch/GPIO read value.
REQ-015 gpio_we  output  1  GPIO register write strobe.
REQ-016 cnt_val  input  32  counter read value.
REQ-017 cnt_we  output  1  counter load strobe.
REQ-018 periph_wdata  output  32  registered peripheral write data.
REQ-019 addr_err  output  1  sticky unmapped-access flag.

Function
REQ-020 Address map:
  - 0x0000_0000-0x0000_0FFF: RAM.
  - 0xE000_0000-0xEFFF_FFFF: GPIO.
  - 0xF000_0000-0xFFFF_FFFF: counter.
  - All other addresses: unmapped.
REQ-021 FSM states are IDLE, RAM_WAIT and DONE; reset state is IDLE.
REQ-022 Transitions out of IDLE:
  - IDLE with no request: stay in IDLE.
  - IDLE with a RAM read: go to RAM_WAIT with the wait counter loaded to RAM_LAT-1.
  - IDLE with any other request: go to DONE.
REQ-023 RAM_WAIT decrements the wait counter each cycle; at zero it captures ram_dout into cpu_rdata and goes to DONE.
REQ-024 DONE asserts MIO_ready for exactly one cycle, then returns to IDLE unconditionally.
REQ-025 A request still high in the IDLE cycle after DONE is treated as a new access.
REQ-026 Access latency from request-high in IDLE to MIO_ready, in cycles:
  - RAM read: RAM_LAT+1.
  - All writes, peripheral reads and unmapped accesses: 1.
REQ-027 Write strobes (ram_we, gpio_we, cnt_we):
  - Each fires for exactly one cycle, in the IDLE cycle that launches the access.
  - At most one strobe is high in any cycle.
REQ-028 Peripheral reads latch gpio_in or cnt_val into cpu_rdata on the launch edge.
REQ-029 cpu_rdata holds its value until the next read completes.
REQ-030 Unmapped read returns 0 in cpu_rdata; unmapped write asserts no strobe; both set addr_err and still complete with MIO_ready.
REQ-031 MemRead and MemWrite high together: the access is a write.
REQ-032 A request dropped during RAM_WAIT aborts the access:
  - Return to IDLE next cycle.
  - No MIO_ready.
  - cpu_rdata unchanged.
REQ-033 ram_addr and ram_din follow cpu_addr and cpu_wdata combinationally.

Reset
REQ-034 On reset: state IDLE, cpu_rdata 0, MIO_ready 0, all strobes 0, periph_wdata 0, addr_err 0, wait counter 0.
REQ-035 Reset asserted mid-access (any state) abandons the access without MIO_ready.
REQ-036 A write strobe is suppressed in any cycle where reset is high.

Structure
REQ-037 A shared package holds the FSM state encodings, the region base/mask constants and the RAM_LAT default.
REQ-038 Address decode is one combinational sub-module, mio_addr_dec, producing one-hot region selects.

Verification
REQ-039 RAM_LAT=2, MemRead, addr 0x0000_0010, ram_dout=0x1234_5678 -> MIO_ready 3 cycles after request-high, cpu_rdata=0x1234_5678.
REQ-040 MemWrite, addr 0xE000_0000, wdata 0x0000_00FF -> gpio_we one cycle, periph_wdata=0xFF, MIO_ready next cycle, ram_we=0.
REQ-041 MemRead, addr 0x0000_2000 -> cpu_rdata=0, addr_err=1, MIO_ready after 1 cycle; addr_err stays 1 until reset.
REQ-042 MemRead and MemWrite together, addr 0x0000_0004 -> ram_we exactly one cycle, MIO_ready after 1 cycle.
REQ-043 RAM read with MemRead dropped one cycle into RAM_WAIT -> no MIO_ready, FSM in IDLE next cycle, cpu_rdata unchanged.
REQ-044 Reset high during RAM_WAIT -> next cycle all outputs at reset values, no MIO_ready.
